// File: rtl/noc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | noc_pkg                                                              |
// | Shared NoC types: flit, ring injection FSM states, default sizing.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package noc_pkg;

  localparam int c_FLIT_W               = 16;
  localparam int c_N_REQ_DEFAULT        = 4;
  localparam int c_STARVE_LIMIT_DEFAULT = 8;

  typedef logic [c_FLIT_W-1:0] flit_t;

  typedef enum logic [0:0] {
    PASS = 1'b0,
    HOLD = 1'b1
  } inj_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter                                                           |
// | Combinational round-robin pick: first request at or after ptr.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any_grant
);

  always_comb begin
    int               w_idx;
    logic [PTR_W-1:0] w_sel;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    w_idx     = 0;
    w_sel     = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = int'(ptr) + i;
      if (w_idx >= N) w_idx = w_idx - N;
      w_sel = PTR_W'(w_idx);
      if (!any_grant && req[w_sel]) begin
        any_grant    = 1'b1;
        grant[w_sel] = 1'b1;
        grant_idx    = w_sel;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ring_inject_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ring_inject_ctrl                                                     |
// | Shares a ring injection slot between through-traffic and N_REQ      |
// | local requesters, with a starvation-driven upstream hold.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ring_inject_ctrl
  import noc_pkg::*;
#(
  parameter int N_REQ        = c_N_REQ_DEFAULT,
  parameter int STARVE_LIMIT = c_STARVE_LIMIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  input  flit_t            req_flit [N_REQ],
  output logic [N_REQ-1:0] req_ready,
  input  flit_t            ring_in_flit,
  input  logic             ring_in_enable,
  output logic             ring_hold,
  output flit_t            out_flit,
  output logic             out_enable,
  output logic             proto_err
);

  localparam int                 c_PTR_W    = $clog2(N_REQ);
  localparam int                 c_CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(STARVE_LIMIT);
  localparam logic [c_CNT_W-1:0] c_CNT_TRIP = c_CNT_W'(STARVE_LIMIT - 1);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(N_REQ - 1);

  inj_state_e         r_state;
  inj_state_e         w_state_next;
  logic [c_PTR_W-1:0] r_rr_ptr;
  logic [c_CNT_W-1:0] r_starve_cnt;
  logic [N_REQ-1:0]   w_arb_req;
  logic [N_REQ-1:0]   w_grant;
  logic [c_PTR_W-1:0] w_grant_idx;
  logic               w_any_grant;
  logic               w_any_valid;
  logic               w_denied;
  logic               w_hold_next;

  assign w_any_valid = |req_valid;
  assign w_denied    = ring_in_enable && w_any_valid;

  // Through-traffic and reset both mask the arbiter, so a grant implies an empty slot
  assign w_arb_req = (rst || ring_in_enable) ? '0 : req_valid;

  rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (c_PTR_W)
  ) u_arb (
    .req       (w_arb_req),
    .ptr       (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .any_grant (w_any_grant)
  );

  assign req_ready = w_grant;

  always_ff @(posedge clk) begin
    if (rst) r_state <= PASS;
    else     r_state <= w_state_next;
  end

  // A violated hold (ring still enabled) leaves the requester starved, so hold again
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      PASS:    if (w_denied && (r_starve_cnt == c_CNT_TRIP)) w_state_next = HOLD;
      HOLD:    w_state_next = w_denied ? HOLD : PASS;
      default: w_state_next = PASS;
    endcase
  end

  always_comb begin
    w_hold_next = (w_state_next == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ring_hold    <= 1'b0;
      proto_err    <= 1'b0;
      r_starve_cnt <= '0;
      r_rr_ptr     <= '0;
      out_enable   <= 1'b0;
      out_flit     <= '0;
    end else begin
      ring_hold <= w_hold_next;
      if ((r_state == HOLD) && ring_in_enable) proto_err <= 1'b1;

      if (w_any_grant || !w_any_valid)  r_starve_cnt <= '0;
      else if (r_starve_cnt != c_CNT_SAT) r_starve_cnt <= r_starve_cnt + 1'b1;

      if (w_any_grant) r_rr_ptr <= (w_grant_idx == c_PTR_LAST) ? '0 : w_grant_idx + 1'b1;

      if (ring_in_enable) begin
        out_enable <= 1'b1;
        out_flit   <= ring_in_flit;
      end else if (w_any_grant) begin
        out_enable <= 1'b1;
        out_flit   <= req_flit[w_grant_idx];
      end else begin
        out_enable <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ring_inject_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ring_inject_ctrl                                                  |
// | Self-checking bench for ring_inject_ctrl with a behavioural model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ring_inject_ctrl;
  import noc_pkg::*;

  localparam int N     = 4;
  localparam int LIMIT = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  flit_t        req_flit [N];
  flit_t        ring_in_flit;
  logic         ring_in_enable;
  logic         ring_hold;
  flit_t        out_flit;
  logic         out_enable;
  logic         proto_err;

  int checks   = 0;
  int failures = 0;

  // Reference model state, derived from the selection/starvation rules
  int           m_ptr;
  int           m_starve;
  int           m_grant;
  bit           m_hold;
  bit           m_proto;
  bit           m_out_en;
  flit_t        m_out_flit;
  logic [N-1:0] m_ready;

  always #5 clk = ~clk;

  ring_inject_ctrl #(
    .N_REQ        (N),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_flit       (req_flit),
    .req_ready      (req_ready),
    .ring_in_flit   (ring_in_flit),
    .ring_in_enable (ring_in_enable),
    .ring_hold      (ring_hold),
    .out_flit       (out_flit),
    .out_enable     (out_enable),
    .proto_err      (proto_err)
  );

  // Commit the model across the clock edge that follows the current inputs
  task automatic advance();
    bit anyv;
    bit nh;
    anyv = |req_valid;
    if (rst) begin
      m_ptr = 0; m_starve = 0; m_hold = 0; m_proto = 0; m_out_en = 0; m_out_flit = '0;
    end else begin
      if (ring_in_enable) begin
        m_out_en = 1; m_out_flit = ring_in_flit;
      end else if (m_grant >= 0) begin
        m_out_en = 1; m_out_flit = req_flit[m_grant];
      end else begin
        m_out_en = 0;
      end
      if (m_hold && ring_in_enable) m_proto = 1;
      nh = ring_in_enable && anyv && (m_starve >= LIMIT - 1);
      if (m_grant >= 0 || !anyv) m_starve = 0;
      else if (m_starve < LIMIT) m_starve = m_starve + 1;
      if (m_grant >= 0) m_ptr = (m_grant + 1) % N;
      m_hold = nh;
    end
  endtask

  // One cycle: model edge, then drive new inputs at the falling edge
  task automatic go(input bit r, input logic [N-1:0] v, input bit en, input flit_t f, input bit obey);
    int idx;
    advance();
    @(negedge clk);
    rst            = r;
    req_valid      = v;
    ring_in_enable = en && !(obey && ring_hold === 1'b1);
    ring_in_flit   = f;
    for (int i = 0; i < N; i++) req_flit[i] = flit_t'($urandom);
    #1;
    m_grant = -1;
    if (!rst && !ring_in_enable) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (m_grant < 0 && req_valid[idx]) m_grant = idx;
      end
    end
    m_ready = (m_grant >= 0) ? (N'(1) << m_grant) : '0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      go(1, '1, 1, flit_t'($urandom), 0);
      checks++;
      if ({req_ready, out_enable, ring_hold, proto_err} !== 7'b0) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got ready/en/hold/perr=%b/%b/%b/%b want 0000/0/0/0",
                 c, req_ready, out_enable, ring_hold, proto_err);
      end
    end
    go(0, '1, 0, '0, 0);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_grant got %b want 0001", req_ready);
    end
  endtask

  task automatic test_priority();
    go(1, '0, 0, '0, 0);
    go(0, 4'b1111, 1, 16'h00A5, 0);
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL priority_ready got %b want 0000", req_ready);
    end
    go(0, '0, 0, '0, 0);
    checks++;
    if (out_enable !== 1'b1 || out_flit !== 16'h00A5) begin
      failures++;
      $display("FAIL priority_fwd got en=%b flit=%h want en=1 flit=00a5", out_enable, out_flit);
    end
  endtask

  task automatic test_round_robin();
    flit_t        exp_flit;
    logic [N-1:0] seq2 [3];
    seq2[0] = 4'b0010; seq2[1] = 4'b1000; seq2[2] = 4'b0010;
    exp_flit = '0;
    go(1, '0, 0, '0, 0);
    for (int i = 0; i < 8; i++) begin
      go(0, 4'b1111, 0, '0, 0);
      checks++;
      if (req_ready !== (4'b0001 << (i % 4))) begin
        failures++;
        $display("FAIL rr_all i=%0d got %b want %b", i, req_ready, 4'b0001 << (i % 4));
      end
      if (i > 0) begin
        checks++;
        if (out_enable !== 1'b1 || out_flit !== exp_flit) begin
          failures++;
          $display("FAIL rr_flit i=%0d got en=%b flit=%h want en=1 flit=%h", i, out_enable, out_flit, exp_flit);
        end
      end
      exp_flit = req_flit[i % 4];
    end
    for (int i = 0; i < 3; i++) begin
      go(0, 4'b1010, 0, '0, 0);
      checks++;
      if (req_ready !== seq2[i]) begin
        failures++;
        $display("FAIL rr_sparse i=%0d got %b want %b", i, req_ready, seq2[i]);
      end
    end
  endtask

  task automatic test_starvation();
    int    hold_cnt;
    int    hold_at;
    flit_t exp_flit;
    hold_cnt = 0; hold_at = 0; exp_flit = '0;
    go(1, '0, 0, '0, 0);
    for (int c = 1; c <= 12; c++) begin
      go(0, 4'b0100, 1, flit_t'($urandom), 1);
      if (ring_hold === 1'b1) begin
        hold_cnt++;
        hold_at = c;
      end
      if (c == 9) begin
        checks++;
        if (req_ready !== 4'b0100) begin
          failures++;
          $display("FAIL starve_grant got %b want 0100", req_ready);
        end
        exp_flit = req_flit[2];
      end
      if (c == 10) begin
        checks++;
        if (out_enable !== 1'b1 || out_flit !== exp_flit) begin
          failures++;
          $display("FAIL starve_flit got en=%b flit=%h want en=1 flit=%h", out_enable, out_flit, exp_flit);
        end
      end
    end
    checks++;
    if (hold_cnt != 1 || hold_at != 9) begin
      failures++;
      $display("FAIL starve_hold got count=%0d cycle=%0d want count=1 cycle=9", hold_cnt, hold_at);
    end
  endtask

  task automatic test_proto_err();
    flit_t prev_ring;
    prev_ring = '0;
    go(1, '0, 0, '0, 0);
    for (int c = 1; c <= 14; c++) begin
      go(0, 4'b0100, 1, flit_t'($urandom), 0);
      if (c >= 10) begin
        checks++;
        if (proto_err !== 1'b1 || ring_hold !== 1'b1 || out_enable !== 1'b1 ||
            out_flit !== prev_ring || req_ready !== 4'b0000) begin
          failures++;
          $display("FAIL proto_violation c=%0d got perr=%b hold=%b en=%b flit=%h ready=%b want 1/1/1/%h/0000",
                   c, proto_err, ring_hold, out_enable, out_flit, req_ready, prev_ring);
        end
      end
      prev_ring = ring_in_flit;
    end
    go(1, '0, 0, '0, 0);
    go(0, '0, 0, '0, 0);
    checks++;
    if (proto_err !== 1'b0 || ring_hold !== 1'b0) begin
      failures++;
      $display("FAIL proto_clear got perr=%b hold=%b want 0/0", proto_err, ring_hold);
    end
  endtask

  task automatic test_reset_mid_hold();
    go(1, '0, 0, '0, 0);
    for (int c = 1; c <= 8; c++) go(0, 4'b0100, 1, flit_t'($urandom), 1);
    go(1, 4'b0100, 0, '0, 0);
    checks++;
    if (ring_hold !== 1'b1 || req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL midhold_enter got hold=%b ready=%b want 1/0000", ring_hold, req_ready);
    end
    go(0, 4'b1111, 0, '0, 0);
    checks++;
    if (ring_hold !== 1'b0 || out_enable !== 1'b0 || req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL midhold_reset got hold=%b en=%b ready=%b want 0/0/0001", ring_hold, out_enable, req_ready);
    end
  endtask

  task automatic test_random();
    go(1, '0, 0, '0, 0);
    for (int c = 0; c < 600; c++) begin
      go($urandom_range(0, 99) == 0, N'($urandom), $urandom_range(0, 2) != 0,
         flit_t'($urandom), $urandom_range(0, 39) != 0);
      checks++;
      if ({out_enable, ring_hold, proto_err, out_flit} !== {m_out_en, m_hold, m_proto, m_out_flit}) begin
        failures++;
        $display("FAIL rand_outputs c=%0d got en/hold/perr/flit=%b/%b/%b/%h want %b/%b/%b/%h",
                 c, out_enable, ring_hold, proto_err, out_flit, m_out_en, m_hold, m_proto, m_out_flit);
      end
      checks++;
      if (req_ready !== m_ready) begin
        failures++;
        $display("FAIL rand_ready c=%0d got %b want %b", c, req_ready, m_ready);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; ring_in_enable = 1'b0; ring_in_flit = '0;
    for (int i = 0; i < N; i++) req_flit[i] = '0;
    m_ptr = 0; m_starve = 0; m_grant = -1; m_hold = 0; m_proto = 0;
    m_out_en = 0; m_out_flit = '0; m_ready = '0;
    test_reset();
    test_priority();
    test_round_robin();
    test_starvation();
    test_proto_err();
    test_reset_mid_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
